// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Iteration counter width: enough to hold 0..N-1 with one bit of headroom.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/ready/valid bundle between a divider client and the divider.
// Latency: n/a (wires only).
// Backpressure: client may only launch a division while ready is high.
interface seq_divider_if #(
    parameter int N = 5
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         ready;
    logic         valid;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
// Latency: combinational.
// Backpressure: none.
module div_step #(
    parameter int N = 5
) (
    input  logic [N:0]   r_in,
    input  logic [N-1:0] q_in,
    input  logic [N-1:0] d,
    output logic [N:0]   r_out,
    output logic [N-1:0] q_out
);
    logic [N:0] rs;
    logic       ge;

    // Shift partial remainder left, pull in the dividend MSB, and restore on underflow.
    // r_in stays below d so r_in[N] is always clear; folding it into the
    // compare means a stray top bit can never be silently dropped.
    always_comb begin
        rs    = {r_in[N-1:0], q_in[N-1]};
        ge    = r_in[N] | (rs >= {1'b0, d});
        r_out = ge ? (rs - {1'b0, d}) : rs;
        q_out = {q_in[N-2:0], ge};
    end
endmodule

// File: rtl/seq_divider.sv
// Unsigned sequential restoring divider, one quotient bit per clock.
// Latency: valid pulses N clocks after the accepting edge, independent of operands.
// Backpressure: ready is low while iterating; start is ignored until ready returns.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    localparam int CW = cnt_width(N);

    div_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]   r_q, r_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] dv_q, dv_d;
    logic         dbz_pend_q, dbz_pend_d;
    logic [N-1:0] quot_q, quot_d;
    logic [N-1:0] rem_q, rem_d;
    logic         dbz_q, dbz_d;
    logic         valid_q, valid_d;

    logic [N:0]   step_r;
    logic [N-1:0] step_q;
    logic         accept;
    logic         last_iter;

    div_step #(.N(N)) u_step (
        .r_in  (r_q),
        .q_in  (q_q),
        .d     (dv_q),
        .r_out (step_r),
        .q_out (step_q)
    );

    assign accept    = (state_q != BUSY) && bus.start;
    assign last_iter = (cnt_q == CW'(N - 1));

    // Next-state, datapath loads and result capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        q_d        = q_q;
        dv_d       = dv_q;
        dbz_pend_d = dbz_pend_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        valid_d    = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d    = BUSY;
                    cnt_d      = '0;
                    r_d        = '0;
                    q_d        = bus.dividend;
                    dv_d       = bus.divisor;
                    dbz_pend_d = (bus.divisor == '0);
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d = DONE;
                    quot_d  = step_q;
                    rem_d   = step_r[N-1:0];
                    dbz_d   = dbz_pend_q;
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            r_q        <= '0;
            q_q        <= '0;
            dv_q       <= '0;
            dbz_pend_q <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            q_q        <= q_d;
            dv_q       <= dv_d;
            dbz_pend_q <= dbz_pend_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.ready       = (state_q != BUSY);
    assign bus.valid       = valid_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed bench for seq_divider with a queue-based scoreboard.
// Latency: each accepted start expects a valid exactly N clocks later.
// Backpressure: stimulus waits on ready; starts while busy must be ignored.
module tb_seq_divider;
    localparam int N = 5;
    localparam int MAXV = (1 << N) - 1;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dbz;
        int acc;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    bit   mon_en;
    bit   prev_valid;
    exp_t sb[$];

    seq_divider_if #(.N(N)) bus ();

    seq_divider #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: plain integer division, divide-by-zero gives all-ones / dividend.
    function automatic exp_t model(input int a, input int b, input int acc);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.acc = acc;
        if (b == 0) begin
            e.q   = MAXV;
            e.r   = a;
            e.dbz = 1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 0;
        end
        return e;
    endfunction

    // Monitor: pop on every valid, check ready against in-flight work, record accepts.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.valid) begin
                chk("valid_not_back_to_back", int'(prev_valid), 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    int   q, r;
                    e = sb.pop_front();
                    q = int'(bus.quotient);
                    r = int'(bus.remainder);
                    chk("quotient", q, e.q);
                    chk("remainder", r, e.r);
                    chk("div_by_zero", int'(bus.div_by_zero), e.dbz);
                    chk("latency", cyc - e.acc, N);
                    if (e.b != 0) begin
                        chk("identity", q * e.b + r, e.a);
                        chk("rem_lt_divisor", int'(r < e.b), 1);
                    end
                end
            end
            chk("ready", int'(bus.ready), int'(sb.size() == 0));
            prev_valid = bus.valid;
            if (rst) begin
                sb.delete();
            end else if (bus.start && bus.ready) begin
                sb.push_back(model(int'(bus.dividend), int'(bus.divisor), cyc + 1));
            end
        end
    end

    task automatic issue(input int a, input int b);
        int n = 0;
        while (!bus.ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.ready) begin
            chk("ready_timeout", 0, 1);
        end
        bus.start    = 1'b1;
        bus.dividend = N'(a);
        bus.divisor  = N'(b);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = N'($urandom);
        bus.divisor  = N'($urandom);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, int'(bus.ready), 1);
        chk({tag, "_valid"}, int'(bus.valid), 0);
        chk({tag, "_quotient"}, int'(bus.quotient), 0);
        chk({tag, "_remainder"}, int'(bus.remainder), 0);
        chk({tag, "_dbz"}, int'(bus.div_by_zero), 0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        mon_en       = 1'b0;
        prev_valid   = 1'b0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        repeat (2) @(posedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Directed cases, including divide by zero followed by a clean divide.
        issue(27, 4);
        drain();
        issue(31, 1);
        drain();
        issue(3, 7);
        drain();
        issue(0, 5);
        drain();
        issue(5, 0);
        drain();
        issue(10, 3);
        drain();

        // Back-to-back: second start lands in the DONE cycle.
        issue(20, 6);
        issue(17, 2);
        drain();

        // Start with other operands while busy must be ignored.
        issue(27, 4);
        bus.start    = 1'b1;
        bus.dividend = N'(9);
        bus.divisor  = N'(9);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        drain();

        // Reset two clocks into a division aborts it.
        issue(29, 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        check_idle("abort");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (N + 2) @(posedge clk);
        #1;
        issue(29, 3);
        drain();

        // Exhaustive sweep of all operand pairs, issued back-to-back.
        for (int a = 0; a <= MAXV; a++) begin
            for (int b = 0; b <= MAXV; b++) begin
                issue(a, b);
            end
        end
        drain();

        // Random operands with random idle gaps.
        for (int k = 0; k < 60; k++) begin
            issue(int'($urandom_range(MAXV, 0)), int'($urandom_range(MAXV, 0)));
            repeat ($urandom_range(N + 3, 0)) @(posedge clk);
            #1;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
